// File: rtl/cla_group_serial_adder_pkg.sv
// Shared definitions for the group-serial carry-lookahead adder:
// controller state encoding and group-count/index-width helpers.
package cla_group_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    function automatic int calcNg(input int n, input int gs);
        return n / gs;
    endfunction

    // A single-group adder still needs a 1-bit index register.
    function automatic int calcIdxWidth(input int ng);
        return (ng > 1) ? $clog2(ng) : 1;
    endfunction

endpackage

// File: rtl/cla_group_serial_adder_expand.sv
// One GS-bit lookahead group: expands the incoming group carry into
// per-bit carries and sum bits, and exports the group G/P terms.
module cla_group_expand
    import cla_group_serial_adder_pkg::*;
#(
    parameter int GS = 8
) (
    input  logic [GS-1:0] i_a,
    input  logic [GS-1:0] i_b,
    input  logic          i_cin,
    output logic [GS-1:0] o_sum,
    output logic          o_grpG,
    output logic          o_grpP,
    output logic          o_cMsb,
    output logic          o_cout
);

    logic [GS-1:0] w_g;
    logic [GS-1:0] w_p;
    logic [GS:0]   w_c;
    logic          w_genAcc;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Group generate is the same recurrence evaluated with a zero carry-in.
    always_comb begin
        w_c      = '0;
        w_c[0]   = i_cin;
        w_genAcc = 1'b0;
        for (int j = 0; j < GS; j++) begin
            w_c[j+1] = w_g[j] | (w_p[j] & w_c[j]);
            w_genAcc = w_g[j] | (w_p[j] & w_genAcc);
        end
    end

    assign o_sum  = w_p ^ w_c[GS-1:0];
    assign o_grpG = w_genAcc;
    assign o_grpP = &w_p;
    assign o_cMsb = w_c[GS-1];
    assign o_cout = w_c[GS];

endmodule

// File: rtl/cla_group_serial_adder.sv
// Multi-cycle N-bit adder reusing one GS-bit lookahead group slice,
// one group per cycle, behind valid/ready request and result interfaces.
module cla_group_serial_adder
    import cla_group_serial_adder_pkg::*;
#(
    parameter int N  = 32,
    parameter int GS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          a,
    input  logic [N-1:0]          b,
    input  logic                  cin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          sum,
    output logic                  cout,
    output logic                  ovf,
    output logic [N/GS-1:0]       grp_g,
    output logic [N/GS-1:0]       grp_p
);

    localparam int NG = calcNg(N, GS);
    localparam int KW = calcIdxWidth(NG);

    if (((N % GS) != 0) || (GS < 2)) begin : gBadParams
        $error("cla_group_serial_adder: N must be a multiple of GS and GS >= 2");
    end

    state_t                  r_state;
    logic [NG-1:0][GS-1:0]   r_a;
    logic [NG-1:0][GS-1:0]   r_b;
    logic [NG-1:0][GS-1:0]   r_sum;
    logic [NG-1:0]           r_g;
    logic [NG-1:0]           r_p;
    logic [KW-1:0]           r_k;
    logic                    r_carry;
    logic                    r_cout;
    logic                    r_ovf;
    logic                    r_inReady;
    logic                    r_outValid;

    logic [GS-1:0]           w_sliceSum;
    logic                    w_grpG;
    logic                    w_grpP;
    logic                    w_cMsb;
    logic                    w_cout;
    logic                    w_lastGroup;

    assign w_lastGroup = (r_k == KW'(NG - 1));

    cla_group_expand #(
        .GS (GS)
    ) u_expand (
        .i_a    (r_a[r_k]),
        .i_b    (r_b[r_k]),
        .i_cin  (r_carry),
        .o_sum  (w_sliceSum),
        .o_grpG (w_grpG),
        .o_grpP (w_grpP),
        .o_cMsb (w_cMsb),
        .o_cout (w_cout)
    );

    // Handshake flags are registered alongside the state so every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_g        <= '0;
            r_p        <= '0;
            r_k        <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_ovf      <= 1'b0;
            r_inReady  <= 1'b1;
            r_outValid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_inReady) begin
                        r_a       <= a;
                        r_b       <= b;
                        r_carry   <= cin;
                        r_k       <= '0;
                        r_sum     <= '0;
                        r_g       <= '0;
                        r_p       <= '0;
                        r_cout    <= 1'b0;
                        r_ovf     <= 1'b0;
                        r_inReady <= 1'b0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_k] <= w_sliceSum;
                    r_g[r_k]   <= w_grpG;
                    r_p[r_k]   <= w_grpP;
                    r_carry    <= w_grpG | (w_grpP & r_carry);
                    if (w_lastGroup) begin
                        r_cout     <= w_cout;
                        r_ovf      <= w_cMsb ^ w_cout;
                        r_outValid <= 1'b1;
                        r_state    <= ST_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_inReady  <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_inReady  <= 1'b1;
                    r_outValid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_inReady;
    assign out_valid = r_outValid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign grp_g     = r_g;
    assign grp_p     = r_p;

endmodule

// File: tb/tb_cla_group_serial_adder.sv
// Scoreboard bench for cla_group_serial_adder: accepted requests push an
// arithmetic reference result, delivered results pop and compare.
module tb_cla_group_serial_adder;

    localparam int N  = 32;
    localparam int GS = 8;
    localparam int NG = N / GS;

    typedef struct {
        logic [N-1:0]  sum;
        logic          cout;
        logic          ovf;
        logic [NG-1:0] g;
        logic [NG-1:0] p;
        int            accCycle;
    } sbEntry_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;

    sbEntry_t sbQ[$];
    int       checkCount = 0;
    int       errorCount = 0;
    int       cycle = 0;
    int       lastAccept = -1;
    bit       b2bMode = 0;
    logic     prevOv = 0;

    cla_group_serial_adder #(
        .N  (N),
        .GS (GS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .grp_g     (grp_g),
        .grp_p     (grp_p)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference built from plain integer addition rather than a carry chain.
    function automatic sbEntry_t makeExp(input logic [N-1:0] aIn, input logic [N-1:0] bIn,
                                         input logic cinIn, input int acc);
        sbEntry_t    e;
        logic [N:0]  full;
        logic [GS:0] part;
        logic [GS-1:0] sa;
        logic [GS-1:0] sb;
        full = {1'b0, aIn} + {1'b0, bIn} + {{N{1'b0}}, cinIn};
        e.sum  = full[N-1:0];
        e.cout = full[N];
        e.ovf  = (aIn[N-1] ^ bIn[N-1] ^ full[N-1]) ^ full[N];
        for (int k = 0; k < NG; k++) begin
            sa = aIn[k*GS +: GS];
            sb = bIn[k*GS +: GS];
            part = {1'b0, sa} + {1'b0, sb};
            e.g[k] = part[GS];
            e.p[k] = ((sa ^ sb) == {GS{1'b1}});
        end
        e.accCycle = acc;
        return e;
    endfunction

    // Push on accept, check latency on the rising edge of out_valid, pop on handoff.
    always @(negedge clk) begin
        sbEntry_t e;
        if (!rst) begin
            if (in_valid && in_ready) begin
                sbQ.push_back(makeExp(a, b, cin, cycle + 1));
                if (b2bMode && lastAccept >= 0)
                    checkOutput("acceptSpacing", 64'(cycle - lastAccept), 64'(NG + 2));
                lastAccept = b2bMode ? cycle : -1;
            end
            if (out_valid && !prevOv) begin
                if (sbQ.size() > 0)
                    checkOutput("latency", 64'(cycle - sbQ[0].accCycle), 64'(NG));
                else
                    checkOutput("unexpectedValid", 64'(1), 64'(0));
            end
            if (out_valid && out_ready) begin
                if (sbQ.size() > 0) begin
                    e = sbQ.pop_front();
                    checkOutput("sum", 64'(sum), 64'(e.sum));
                    checkOutput("cout", 64'(cout), 64'(e.cout));
                    checkOutput("ovf", 64'(ovf), 64'(e.ovf));
                    checkOutput("grpG", 64'(grp_g), 64'(e.g));
                    checkOutput("grpP", 64'(grp_p), 64'(e.p));
                end else begin
                    checkOutput("unexpectedResult", 64'(1), 64'(0));
                end
            end
        end
        prevOv = out_valid;
    end

    task automatic applyStimulus(input logic [N-1:0] aIn, input logic [N-1:0] bIn,
                                 input logic cinIn, input bit hold);
        bit accepted;
        accepted = 0;
        a        = aIn;
        b        = bIn;
        cin      = cinIn;
        in_valid = 1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #2;
                accepted = 1;
            end
        end
        if (!accepted) checkOutput("acceptTimeout", 64'(0), 64'(1));
        if (!hold) in_valid = 0;
    endtask

    task automatic waitDrain();
        bit drained;
        drained = 0;
        for (int i = 0; i < 100 && !drained; i++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && !out_valid) drained = 1;
        end
        if (!drained) checkOutput("drainTimeout", 64'(0), 64'(1));
        @(posedge clk);
        #2;
    endtask

    initial begin
        bit seen;
        rst       = 1;
        in_valid  = 0;
        a         = '0;
        b         = '0;
        cin       = 0;
        out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetInReady", 64'(in_ready), 64'(1));
        checkOutput("resetOutValid", 64'(out_valid), 64'(0));
        checkOutput("resetSum", 64'(sum), 64'(0));
        checkOutput("resetFlags", 64'({cout, ovf, grp_g, grp_p}), 64'(0));
        #1;
        rst = 0;
        @(posedge clk);
        #2;

        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        waitDrain();
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        waitDrain();
        applyStimulus(32'h0000_0000, 32'h0000_0000, 1, 0);
        waitDrain();

        // Result must hold steady while the consumer stalls.
        out_ready = 0;
        applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        if (!seen) checkOutput("bpValidTimeout", 64'(0), 64'(1));
        for (int i = 0; i < 10; i++) begin
            checkOutput("bpSum", 64'(sum), 64'h2143_6587);
            checkOutput("bpValid", 64'(out_valid), 64'(1));
            checkOutput("bpInReady", 64'(in_ready), 64'(0));
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bpAfterValid", 64'(out_valid), 64'(0));
        checkOutput("bpAfterInReady", 64'(in_ready), 64'(1));
        waitDrain();

        // Asynchronous reset during the second RUN cycle discards the operation.
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        @(posedge clk);
        #2;
        checkOutput("partialSum", 64'(sum), 64'h0000_00FE);
        rst = 1;
        #1;
        checkOutput("midRstSum", 64'(sum), 64'(0));
        checkOutput("midRstOutValid", 64'(out_valid), 64'(0));
        checkOutput("midRstInReady", 64'(in_ready), 64'(1));
        checkOutput("midRstFlags", 64'({cout, ovf, grp_g, grp_p}), 64'(0));
        sbQ.delete();
        @(posedge clk);
        #2;
        rst = 0;
        applyStimulus(32'd5, 32'd7, 0, 0);
        waitDrain();

        // Back-to-back issue with operands scrambled while each request runs.
        b2bMode = 1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($urandom, $urandom, 1'($urandom_range(0, 1)), (i < 2));
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            @(posedge clk);
            #2;
            @(posedge clk);
            #2;
        end
        waitDrain();
        b2bMode = 0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/cla_group_serial_adder.md
Name: cla_group_serial_adder

Overview:
- Multi-cycle N-bit carry-lookahead adder built from GS-bit lookahead groups.
- Consumes one group per cycle and ripples the group carry through a register between cycles.
- Inside each group, the carry is expanded back into per-bit carries and sum bits; it also exports that group's G/P.
- Sits behind a valid/ready request interface and in front of a valid/ready result interface, for area-constrained datapaths that reuse one group slice.

Parameters:
- N, 32, operand width in bits; must be a multiple of GS.
- GS, 8, group size in bits; must be at least 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request.
- a  input  N  operand A.
- b  input  N  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  N  A+B+cin, modulo 2^N.
- cout  output  1  carry out of bit N-1.
- ovf  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.
- grp_g  output  N/GS  group generate of each group, captured as that group is processed.
- grp_p  output  N/GS  group propagate of each group.

Behaviour:
- Derived value: NG = N/GS.
- States:
  - IDLE: in_ready=1.
  - RUN: group index k from 0 to NG-1.
  - DONE: out_valid=1.
- IDLE -> RUN:
  - Transition on in_valid & in_ready.
  - Latch a, b and cin into operand registers.
  - Set carry register to cin and k to 0.
  - Clear sum, grp_g and grp_p.
- RUN, each cycle, for slice k (bits k*GS .. k*GS+GS-1):
  - Per-bit g = a&b, p = a^b.
  - Bit carries are computed by lookahead: c[j+1] = g[j] | (p[j]&c[j]), with c[0] taken from the carry register.
  - Sum bits = p ^ c.
  - Group G = lookahead generate over the slice.
  - Group P = AND of all bit propagates.
  - Write sum slice k, grp_g[k] and grp_p[k].
  - Carry register <= G | (P & carry).
  - When k = NG-1, also capture cout and ovf (carry into bit N-1 XOR cout), then go to DONE. Otherwise k <= k+1.
- Latency: out_valid rises exactly NG cycles after the accepting edge (4 cycles for the defaults).
- DONE:
  - sum, cout, ovf, grp_g and grp_p are held stable while out_valid=1 and out_ready=0.
  - On out_ready=1, go to IDLE; out_valid drops the following cycle.
  - in_ready=0 in RUN and DONE. A request cannot be accepted in the same cycle as result handoff, so the minimum issue interval is NG+2 cycles.
- in_valid while not ready is ignored. Operands are sampled only at the accepting edge; changes to a, b or cin during RUN do not affect the result.
- Reset, including mid-RUN or in DONE:
  - State = IDLE, in_ready=1, out_valid=0.
  - sum, cout, ovf, grp_g, grp_p, carry register and k all return to 0.
  - An in-flight operation is discarded with no output.
- Outputs are registered; sum bits of groups not yet processed read 0 during RUN.
- Elaboration error if N % GS != 0 or GS < 2.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, RUN, DONE);
  - a function computing NG and the index width $clog2(NG), minimum 1.
- Natural sub-module: cla_group_expand. It is purely combinational.
  - Inputs: GS-bit a/b slice and carry-in.
  - Outputs: GS-bit sum, group G, group P, carry into the slice MSB, carry-out.
  - The top instantiates it once and muxes the slice by k.

Test Plan:
- a=0xFFFFFFFF, b=0x00000001, cin=0 -> after 4 cycles: sum=0x00000000, cout=1, ovf=0, grp_g=4'b0001, grp_p=4'b1110.
- a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- a=0, b=0, cin=1 -> sum=0x00000001, cout=0; grp_g=0, grp_p=0.
- Backpressure:
  - Stimulus: a=0x12345678, b=0x0F0F0F0F, out_ready held 0 for 10 cycles.
  - Required: sum=0x21436587 held stable with out_valid=1 and in_ready=0 throughout.
  - Required: after out_ready=1 for one cycle, the next cycle has out_valid=0 and in_ready=1.
- Reset mid-op:
  - Stimulus: assert rst in the 2nd RUN cycle.
  - Required: outputs zero and state IDLE immediately (asynchronous).
  - Required: a new request a=5, b=7 after release yields sum=12 with latency 4.
- Back-to-back:
  - Stimulus: in_valid held high with three random operand pairs, out_ready=1 throughout.
  - Required: each result matches the reference A+B+cin.
  - Required: accepts are spaced exactly 6 cycles apart.
  - Required: operand changes during RUN do not affect results.
